// File: rtl/reg_if_pkg.sv
// Shared definitions for the register-write arbiter.
//   arb_state_e   : arbiter FSM states (IDLE, BUSY)
//   REG_STRB_W    : default byte-strobe width for a 32-bit data path
//   tmo_cnt_width : number of bits needed to hold count values 0..timeout-1
package reg_if_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int REG_DATA_W = 32;
    localparam int REG_STRB_W = REG_DATA_W / 8;

    // clog2(timeout), never less than 1 so the counter always has a bit
    function automatic int tmo_cnt_width(input int timeout);
        int w;
        w = 1;
        while ((1 << w) < timeout) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker, purely combinational.
//   i_req        : request vector {req1, req0}
//   i_ptr        : preferred requester when both request
//   o_gnt_onehot : one-hot grant, all zero when nobody requests
//   o_gnt_id     : index of the granted requester (0 when nobody requests)
// The pointer register lives in the parent.
module rr_arb2
    import reg_if_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt_onehot,
    output logic       o_gnt_id
);

    always_comb begin
        o_gnt_onehot = 2'b00;
        o_gnt_id     = 1'b0;
        case (i_req)
            2'b01: begin
                o_gnt_onehot = 2'b01;
                o_gnt_id     = 1'b0;
            end
            2'b10: begin
                o_gnt_onehot = 2'b10;
                o_gnt_id     = 1'b1;
            end
            2'b11: begin
                o_gnt_onehot = i_ptr ? 2'b10 : 2'b01;
                o_gnt_id     = i_ptr;
            end
            default: begin
                o_gnt_onehot = 2'b00;
                o_gnt_id     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter for one register-bank write port shared by two
// requesters (s0: AXI-lite write bridge, s1: core-side status updater).
// One write is in flight at a time; every write takes at least one BUSY
// cycle followed by one IDLE cycle.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   s<i>_reg_wr_addr/data/strb/en : requester payload and request
//   s<i>_reg_wr_wait         : request pending and not yet acked
//   s<i>_reg_wr_ack          : one-cycle completion pulse to the requester
//   m_reg_wr_addr/data/strb/en : downstream write, payload latched at grant
//   m_reg_wr_wait            : downstream stall (freezes the timeout)
//   m_reg_wr_ack             : downstream completion (passed through same cycle)
//   grant_id                 : current/last granted requester
//   timeout_err              : sticky, set when a grant ended by timeout
//
// Build option REG_WR_ARB_TIMEOUT_EN: when defined, a grant that sees
// TIMEOUT non-stalled cycles without ack is completed by the arbiter itself.
// When undefined, BUSY waits for m_reg_wr_ack indefinitely and timeout_err is 0.
module reg_wr_arbiter
    import reg_if_pkg::*;
#(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = REG_STRB_W,   // must equal DATA_WIDTH/8
    parameter int TIMEOUT    = 4             // must be >= 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s0_reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] s0_reg_wr_data,
    input  logic [STRB_WIDTH-1:0] s0_reg_wr_strb,
    input  logic                  s0_reg_wr_en,
    output logic                  s0_reg_wr_wait,
    output logic                  s0_reg_wr_ack,
    input  logic [ADDR_WIDTH-1:0] s1_reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] s1_reg_wr_data,
    input  logic [STRB_WIDTH-1:0] s1_reg_wr_strb,
    input  logic                  s1_reg_wr_en,
    output logic                  s1_reg_wr_wait,
    output logic                  s1_reg_wr_ack,
    output logic [ADDR_WIDTH-1:0] m_reg_wr_addr,
    output logic [DATA_WIDTH-1:0] m_reg_wr_data,
    output logic [STRB_WIDTH-1:0] m_reg_wr_strb,
    output logic                  m_reg_wr_en,
    input  logic                  m_reg_wr_wait,
    input  logic                  m_reg_wr_ack,
    output logic                  grant_id,
    output logic                  timeout_err
);

    arb_state_e            r_state, w_state_next;
    logic                  r_grant, w_grant_next;
    logic                  r_ptr, w_ptr_next;
    logic                  r_tmo_err, w_tmo_err_next;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
    logic [DATA_WIDTH-1:0] r_data, w_data_next;
    logic [STRB_WIDTH-1:0] r_strb, w_strb_next;

    logic [1:0] w_req;
    logic [1:0] w_gnt_onehot;
    logic       w_gnt_id;
    logic       w_tmo_hit;
    logic       w_done;

    assign w_req = {s1_reg_wr_en, s0_reg_wr_en};

    rr_arb2 u_pick (
        .i_req        (w_req),
        .i_ptr        (r_ptr),
        .o_gnt_onehot (w_gnt_onehot),
        .o_gnt_id     (w_gnt_id)
    );

`ifdef REG_WR_ARB_TIMEOUT_EN
    localparam int                CNT_W    = tmo_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count, w_count_next;

    // Ack arriving in the same cycle the count is exhausted wins: that is a
    // normal completion, not a timeout.
    assign w_tmo_hit = (r_state == BUSY) && (r_count == '0)
                       && !m_reg_wr_ack && !m_reg_wr_wait;

    always_comb begin
        w_count_next = r_count;
        if (r_state == IDLE) begin
            if (|w_gnt_onehot) begin
                w_count_next = CNT_LOAD;
            end
        end else if (!m_reg_wr_wait && !m_reg_wr_ack && (r_count != '0)) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end
`else
    logic w_unused;

    assign w_tmo_hit = 1'b0;
    // Stall input and TIMEOUT only matter to the timeout counter.
    assign w_unused  = m_reg_wr_wait ^ (TIMEOUT < 2);
`endif

    assign w_done = (r_state == BUSY) && (m_reg_wr_ack || w_tmo_hit);

    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_ptr_next     = r_ptr;
        w_tmo_err_next = r_tmo_err;
        w_addr_next    = r_addr;
        w_data_next    = r_data;
        w_strb_next    = r_strb;
        case (r_state)
            IDLE: begin
                if (|w_gnt_onehot) begin
                    w_state_next = BUSY;
                    w_grant_next = w_gnt_id;
                    w_addr_next  = w_gnt_id ? s1_reg_wr_addr : s0_reg_wr_addr;
                    w_data_next  = w_gnt_id ? s1_reg_wr_data : s0_reg_wr_data;
                    w_strb_next  = w_gnt_id ? s1_reg_wr_strb : s0_reg_wr_strb;
                end
            end
            BUSY: begin
                if (w_done) begin
                    w_state_next = IDLE;
                    w_ptr_next   = ~r_grant;
                    if (w_tmo_hit) begin
                        w_tmo_err_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= 1'b0;
            r_ptr     <= 1'b0;
            r_tmo_err <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_strb    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_grant   <= w_grant_next;
            r_ptr     <= w_ptr_next;
            r_tmo_err <= w_tmo_err_next;
            r_addr    <= w_addr_next;
            r_data    <= w_data_next;
            r_strb    <= w_strb_next;
        end
    end

    assign m_reg_wr_en   = (r_state == BUSY);
    assign m_reg_wr_addr = r_addr;
    assign m_reg_wr_data = r_data;
    assign m_reg_wr_strb = r_strb;
    assign grant_id      = r_grant;
    assign timeout_err   = r_tmo_err;

    assign s0_reg_wr_ack  = w_done && !r_grant;
    assign s1_reg_wr_ack  = w_done &&  r_grant;
    assign s0_reg_wr_wait = s0_reg_wr_en && !s0_reg_wr_ack;
    assign s1_reg_wr_wait = s1_reg_wr_en && !s1_reg_wr_ack;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Testbench for reg_wr_arbiter: directed scenarios with literal expectations,
// then randomized requesters/downstream checked every cycle against a
// transaction-level model of the arbiter.
module tb_reg_wr_arbiter;

    localparam int AW  = 40;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 4;
`ifdef REG_WR_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_en;
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] req_data [2];
    logic [SW-1:0] req_strb [2];
    logic          s0_wait, s0_ack, s1_wait, s1_ack;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_strb;
    logic          m_en, m_wait, m_ack;
    logic          grant_id, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state (transaction level)
    bit            mdl_busy, mdl_gid, mdl_ptr, mdl_err;
    int            mdl_elapsed;   // non-stalled cycles spent in the current grant
    logic [AW-1:0] mdl_addr;
    logic [DW-1:0] mdl_data;
    logic [SW-1:0] mdl_strb;
    logic [1:0]    last_ack;
    logic [1:0]    ack_e, wait_e;
    bit            tmo_now;
    int            win;

    reg_wr_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s0_reg_wr_addr (req_addr[0]),
        .s0_reg_wr_data (req_data[0]),
        .s0_reg_wr_strb (req_strb[0]),
        .s0_reg_wr_en   (req_en[0]),
        .s0_reg_wr_wait (s0_wait),
        .s0_reg_wr_ack  (s0_ack),
        .s1_reg_wr_addr (req_addr[1]),
        .s1_reg_wr_data (req_data[1]),
        .s1_reg_wr_strb (req_strb[1]),
        .s1_reg_wr_en   (req_en[1]),
        .s1_reg_wr_wait (s1_wait),
        .s1_reg_wr_ack  (s1_ack),
        .m_reg_wr_addr  (m_addr),
        .m_reg_wr_data  (m_data),
        .m_reg_wr_strb  (m_strb),
        .m_reg_wr_en    (m_en),
        .m_reg_wr_wait  (m_wait),
        .m_reg_wr_ack   (m_ack),
        .grant_id       (grant_id),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_addr[i] = a;
        req_data[i] = d;
        req_strb[i] = s;
        req_en[i]   = 1'b1;
    endtask

    // Randomized requester and downstream behaviour, called just after a rising edge.
    task automatic rand_step();
        for (int i = 0; i < 2; i++) begin
            if (req_en[i]) begin
                if (last_ack[i]) begin
                    req_en[i] = 1'b0;
                end else if (!(mdl_busy && (mdl_gid == 1'(i))) && ($urandom_range(0, 99) < 3)) begin
                    req_en[i] = 1'b0;
                end
            end else if ($urandom_range(0, 99) < 40) begin
                set_req(i, AW'({$urandom(), $urandom()}), DW'($urandom()), SW'($urandom()));
            end
        end
        if (m_en) begin
            m_ack  = ($urandom_range(0, 99) < 30);
            m_wait = ($urandom_range(0, 99) < 25);
        end else begin
            m_ack  = 1'b0;
            m_wait = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain_step();
        for (int i = 0; i < 2; i++) begin
            if (req_en[i] && (last_ack[i] || !(mdl_busy && (mdl_gid == 1'(i))))) begin
                req_en[i] = 1'b0;
            end
        end
        m_wait = 1'b0;
        m_ack  = m_en;
    endtask

    // Compare process: model expectations vs DUT on every falling edge,
    // then advance the model using the inputs the DUT will sample next.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mdl_busy    = 1'b0;
                mdl_gid     = 1'b0;
                mdl_ptr     = 1'b0;
                mdl_err     = 1'b0;
                mdl_elapsed = 0;
                mdl_addr    = '0;
                mdl_data    = '0;
                mdl_strb    = '0;
            end
            tmo_now = TMO_ON && mdl_busy && !m_ack && !m_wait && (mdl_elapsed >= TMO - 1);
            for (int i = 0; i < 2; i++) begin
                ack_e[i]  = mdl_busy && (mdl_gid == 1'(i)) && (m_ack || tmo_now);
                wait_e[i] = req_en[i] && !ack_e[i];
            end
            chk("m_en", m_en, mdl_busy);
            chk("grant_id", grant_id, mdl_gid);
            chk("timeout_err", timeout_err, mdl_err);
            chk("s0_ack", s0_ack, ack_e[0]);
            chk("s1_ack", s1_ack, ack_e[1]);
            chk("s0_wait", s0_wait, wait_e[0]);
            chk("s1_wait", s1_wait, wait_e[1]);
            if (mdl_busy || rst) begin
                chk("m_addr", m_addr, mdl_addr);
                chk("m_data", m_data, mdl_data);
                chk("m_strb", m_strb, mdl_strb);
            end
            last_ack = ack_e;
            if (!rst) begin
                if (!mdl_busy) begin
                    if (req_en != 2'b00) begin
                        win         = (req_en == 2'b11) ? int'(mdl_ptr) : (req_en[1] ? 1 : 0);
                        mdl_busy    = 1'b1;
                        mdl_gid     = 1'(win);
                        mdl_addr    = req_addr[win];
                        mdl_data    = req_data[win];
                        mdl_strb    = req_strb[win];
                        mdl_elapsed = 0;
                    end
                end else if (m_ack || tmo_now) begin
                    $display("write gid=%0d addr=%010h data=%08h strb=%h end=%s",
                             mdl_gid, mdl_addr, mdl_data, mdl_strb, tmo_now ? "timeout" : "ack");
                    mdl_busy = 1'b0;
                    mdl_ptr  = !mdl_gid;
                    if (tmo_now) mdl_err = 1'b1;
                end else if (!m_wait) begin
                    mdl_elapsed++;
                end
            end
        end
    end

    initial begin
        req_en   = 2'b00;
        last_ack = 2'b00;
        m_wait   = 1'b0;
        m_ack    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_addr[i] = '0;
            req_data[i] = '0;
            req_strb[i] = '0;
        end
        rst = 1'b0;
        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst_m_en", m_en, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_addr", m_addr, 0);
        rst = 1'b0;

        // single request, acked in the first BUSY cycle
        tick();
        set_req(0, 40'h10, 32'hDEADBEEF, 4'hF);
        #1;
        chk("single_wait_pre", s0_wait, 1);
        chk("single_en_pre", m_en, 0);
        tick();
        chk("single_m_en", m_en, 1);
        chk("single_addr", m_addr, 40'h10);
        chk("single_data", m_data, 32'hDEADBEEF);
        chk("single_strb", m_strb, 4'hF);
        chk("single_gid", grant_id, 0);
        m_ack = 1'b1;
        #1;
        chk("single_ack", s0_ack, 1);
        chk("single_wait_ack", s0_wait, 0);
        tick();
        req_en[0] = 1'b0;
        m_ack     = 1'b0;
        #1;
        chk("single_idle", m_en, 0);
        chk("single_ack_end", s0_ack, 0);

        // simultaneous requests from reset: s0 first, then s1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 40'h4, 32'h11111111, 4'h3);
        set_req(1, 40'h8, 32'h22222222, 4'hC);
        tick();
        chk("sim_gid0", grant_id, 0);
        chk("sim_addr0", m_addr, 40'h4);
        chk("sim_s1_wait", s1_wait, 1);
        m_ack = 1'b1;
        #1;
        chk("sim_s0_ack", s0_ack, 1);
        chk("sim_s1_noack", s1_ack, 0);
        tick();
        req_en[0] = 1'b0;
        m_ack     = 1'b0;
        #1;
        chk("sim_idle_en", m_en, 0);
        chk("sim_idle_s1_wait", s1_wait, 1);
        tick();
        chk("sim_gid1", grant_id, 1);
        chk("sim_addr1", m_addr, 40'h8);
        m_ack = 1'b1;
        tick();
        req_en[1] = 1'b0;
        m_ack     = 1'b0;

        // alternation over 8 writes with both requesters kept busy
        tick();
        req_en = 2'b11;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k > 0) req_en[(k - 1) % 2] = 1'b1;
            chk("alt_gid", grant_id, 64'(k % 2));
            chk("alt_m_en", m_en, 1);
            m_ack = 1'b1;
            tick();
            m_ack = 1'b0;
            req_en[k % 2] = 1'b0;
        end
        req_en = 2'b00;

        // downstream stall for 10 cycles, then ack
        tick();
        set_req(0, 40'h20, 32'hCAFEF00D, 4'h5);
        m_wait = 1'b1;
        tick();
        for (int j = 0; j < 10; j++) begin
            chk("stall_m_en", m_en, 1);
            chk("stall_addr", m_addr, 40'h20);
            chk("stall_data", m_data, 32'hCAFEF00D);
            chk("stall_noack", s0_ack, 0);
            tick();
        end
        m_wait = 1'b0;
        m_ack  = 1'b1;
        #1;
        chk("stall_ack", s0_ack, 1);
        chk("stall_err", timeout_err, 0);
        tick();
        req_en[0] = 1'b0;
        m_ack     = 1'b0;

        // grant s1 and never ack downstream
        tick();
        set_req(1, 40'h30, 32'h0BADF00D, 4'hF);
        tick();
        for (int c = 1; c <= 12; c++) begin
            chk("tmo_ack", s1_ack, 64'(TMO_ON && (c == TMO)));
            chk("tmo_busy", m_en, 1);
            if (TMO_ON && (c == TMO)) break;
            tick();
        end
        tick();
        chk("tmo_m_en_after", m_en, 64'(!TMO_ON));
        chk("tmo_err_set", timeout_err, 64'(TMO_ON));
        req_en[1] = !TMO_ON;
        m_ack     = !TMO_ON;
        #1;
        chk("tmo_release_ack", s1_ack, 64'(!TMO_ON));
        tick();
        req_en[1] = 1'b0;
        m_ack     = 1'b0;

        // next request is served normally; timeout_err is sticky
        tick();
        set_req(0, 40'h50, 32'h12345678, 4'h1);
        tick();
        chk("post_tmo_gid", grant_id, 0);
        chk("post_tmo_en", m_en, 1);
        m_ack = 1'b1;
        #1;
        chk("post_tmo_ack", s0_ack, 1);
        tick();
        req_en[0] = 1'b0;
        m_ack     = 1'b0;
        chk("post_tmo_err_sticky", timeout_err, 64'(TMO_ON));

        // reset in the middle of a write, request kept pending across reset
        tick();
        set_req(1, 40'h40, 32'hA5A5A5A5, 4'hA);
        tick();
        chk("rmw_gid1", grant_id, 1);
        chk("rmw_busy", m_en, 1);
        rst = 1'b1;
        #1;
        chk("rmw_m_en", m_en, 0);
        chk("rmw_gid0", grant_id, 0);
        chk("rmw_ack", s1_ack, 0);
        chk("rmw_err", timeout_err, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rmw_regrant_en", m_en, 1);
        chk("rmw_regrant_gid", grant_id, 1);
        chk("rmw_regrant_addr", m_addr, 40'h40);
        m_ack = 1'b1;
        tick();
        req_en[1] = 1'b0;
        m_ack     = 1'b0;

        // randomized traffic
        tick();
        for (int n = 0; n < 4000; n++) begin
            rand_step();
            tick();
        end
        for (int n = 0; n < 60; n++) begin
            drain_step();
            tick();
        end
        m_ack = 1'b0;
        #1;
        chk("drain_idle", m_en, 0);
        chk("drain_s0_wait", s0_wait, 0);
        chk("drain_s1_wait", s1_wait, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Two-requester round-robin arbiter for one register-interface write port: addr/data/strb/en with wait/ack.
- Requester 0 is the AXI-lite write bridge (host configuration).
- Requester 1 is the core-side status/config updater (systolic-array control).
- The single downstream port drives the shared register bank; the arbiter sequences one write at a time and returns ack/wait to the granted requester.

Parameters:
- ADDR_WIDTH, 40, register address width.
- DATA_WIDTH, 32, write data width.
- STRB_WIDTH, 4, byte strobe width; must equal DATA_WIDTH/8.
- TIMEOUT, 4, max non-wait cycles a grant waits for downstream ack; must be >= 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s0_reg_wr_addr / s1_reg_wr_addr  in  ADDR_WIDTH  requester address.
- s0_reg_wr_data / s1_reg_wr_data  in  DATA_WIDTH  requester write data.
- s0_reg_wr_strb / s1_reg_wr_strb  in  STRB_WIDTH  requester byte strobes.
- s0_reg_wr_en / s1_reg_wr_en  in  1  request; held with addr/data/strb stable until ack.
- s0_reg_wr_wait / s1_reg_wr_wait  out  1  request pending, not yet acked.
- s0_reg_wr_ack / s1_reg_wr_ack  out  1  one-cycle write-complete pulse.
- m_reg_wr_addr  out  ADDR_WIDTH  downstream address.
- m_reg_wr_data  out  DATA_WIDTH  downstream data.
- m_reg_wr_strb  out  STRB_WIDTH  downstream strobes.
- m_reg_wr_en  out  1  downstream write enable.
- m_reg_wr_wait  in  1  downstream stall; freezes timeout.
- m_reg_wr_ack  in  1  downstream completion.
- grant_id  out  1  index of current/last grant.
- timeout_err  out  1  sticky flag: a grant ended by timeout.

Behaviour:
- Reset values: state=IDLE, m_reg_wr_en=0, m_addr/data/strb=0, grant_id=0, rr_ptr=0 (requester 0 preferred), timeout_err=0, s*_ack=0, count=0.
- States: IDLE, BUSY.
- IDLE arbitration:
  - Only one requester asserting en: grant it.
  - Both asserting: grant rr_ptr.
  - Next edge: state=BUSY, grant_id=winner, m_addr/data/strb registered from winner, m_reg_wr_en=1, count=TIMEOUT-1.
  - Grant latency is one cycle from en sampled in IDLE to m_reg_wr_en high.
- BUSY:
  - m_reg_wr_en held 1; m_* payload held constant.
  - s<grant>_reg_wr_ack = m_reg_wr_ack (combinational pass-through, same cycle).
  - On m_reg_wr_ack: next edge state=IDLE, m_reg_wr_en=0, rr_ptr=~grant_id.
  - Requester deasserts en the cycle after ack, so IDLE never re-grants a completed request.
- s<i>_reg_wr_wait = s<i>_reg_wr_en && !s<i>_reg_wr_ack. It covers both the losing requester and the granted one while unacked.
- No back-to-back grants: minimum two cycles per write (BUSY plus IDLE). Throughput is one write per two cycles when downstream acks immediately.
- grant_id holds its value in IDLE.
- Requester deasserting en while not granted: dropped silently, no ack.
- Deassert while granted is illegal; the arbiter ignores it and completes the latched write.
- Reset mid-BUSY: immediate return to reset values; the in-flight write is abandoned with no ack.

Optional Feature:
- REG_WR_ARB_TIMEOUT_EN defined:
  - In BUSY, count decrements each cycle with !m_reg_wr_wait && !m_reg_wr_ack and count!=0.
  - If count==0 && !m_reg_wr_ack && !m_reg_wr_wait: s<grant>_reg_wr_ack pulses that cycle; next edge state=IDLE, m_reg_wr_en=0, rr_ptr flips, timeout_err<=1 (sticky until rst).
  - Ack in the same cycle as count reaching 0 counts as a normal completion; timeout_err is unchanged.
- Not defined: no counter logic; BUSY waits indefinitely for m_reg_wr_ack; timeout_err tied 0.

Decomposition:
- Shared package reg_if_pkg:
  - typedef arb_state_e {IDLE, BUSY}.
  - Localparam REG_STRB_W = DATA_WIDTH/8 default helper.
  - Timeout width function clog2(TIMEOUT).
- One sub-module: rr_arb2 (2-input round-robin picker: req[1:0], ptr -> gnt_onehot, gnt_id). Purely combinational; the pointer register stays in the parent.

Test Plan:
- Single request: s0 en, addr=0x10, data=0xDEADBEEF, strb=0xF, downstream acks first BUSY cycle -> m_en high 1 cycle after en, m payload matches, s0_ack pulses 1 cycle, s0_wait high only before ack.
- Simultaneous requests from reset: s0 and s1 both en, addr 0x4/0x8 -> s0 granted first (rr_ptr=0), then s1, grant_id 0 then 1, s1_wait high throughout s0's write; repeat with both -> s1 first (ptr flipped after s1? no: ptr=0 after s1 grant, so s0) alternation verified over 8 writes.
- Downstream stall: m_wait=1 for 10 cycles then ack -> m_en and payload stable all 10 cycles, no ack to requester until m_ack, timeout_err stays 0.
- Timeout (macro on, TIMEOUT=4): grant s1, never ack, m_wait=0 -> s1_ack pulses on 4th BUSY cycle, timeout_err=1 and sticky, next request served normally. Macro off: same stimulus -> BUSY indefinitely, no ack.
- Reset mid-write: assert rst during BUSY -> m_en=0, acks=0, grant_id=0 asynchronously; after release, pending s1 request granted 1 cycle after first IDLE sample.
